irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 16, number of local interrupt lines (2..32).
REQ-002 Parameter EDGE_MASK, default '0, per-line mode: 1 = rising-edge latched, 0 = level.
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser depth per line (1..3).
REQ-004 Parameter VEC_STRIDE, default 4, vector offset bytes per line id.
REQ-005 Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-low.
REQ-006 clk  in  1  core clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 irq_i  in  NUM_IRQ  raw asynchronous interrupt lines.
REQ-009 en_wr_i  in  1  enable-register write strobe.
REQ-010 en_data_i  in  NUM_IRQ  new per-line enable value.
REQ-011 global_ie_i  in  1  mstatus.MIE.
REQ-012 stall_i  in  1  pipeline stall; blocks new requests.
REQ-013 trap_ack_i  in  1  CSR accepted the trap.
REQ-014 complete_i  in  1  handler finished (mret of local irq).
REQ-015 complete_id_i  in  $clog2(NUM_IRQ)  id being completed.
REQ-016 en_o  out  NUM_IRQ  enable register.
REQ-017 pend_o  out  NUM_IRQ  pending vector.
REQ-018 trap_req_o  out  1  interrupt request to CSR.
REQ-019 trap_id_o  out  $clog2(NUM_IRQ)  id being requested or served.
REQ-020 trap_cause_o  out  32  mcause value.
REQ-021 trap_offset_o  out  32  vector offset from mtvec base.
REQ-022 busy_o  out  1  state != IDLE.

Function
REQ-023 Each irq_i bit passes through SYNC_STAGES flops before any use.
REQ-024 Level lines: pend = synchronised level, not cleared by ack.
REQ-025 Edge lines: pend set on synchronised 0->1, cleared on trap_ack_i for trap_id_o; set wins over clear in the same cycle.
REQ-026 en_wr_i loads en_o next cycle; disabling a line does not clear its pending bit.
REQ-027 Candidate = lowest index of (pend & en_o); index 0 highest priority.
REQ-028 FSM states IDLE, REQ, ACTIVE.
REQ-029 IDLE->REQ when global_ie_i & candidate valid & !stall_i; id latched at transition.
REQ-030 REQ: trap_req_o = 1, id/cause/offset held stable until trap_ack_i, even if the line drops; REQ->ACTIVE on trap_ack_i.
REQ-031 ACTIVE: no new request (no nesting); ACTIVE->IDLE on complete_i with complete_id_i == trap_id_o; mismatched complete ignored.
REQ-032 complete_i outside ACTIVE ignored.
REQ-033 trap_cause_o = 0x8000_0000 | (16 + id); trap_offset_o = id * VEC_STRIDE, both zero-extended to 32 bits.
REQ-034 Request latency: edge on irq_i to trap_req_o = SYNC_STAGES + 2 cycles (sync, pend flop, FSM flop) with all gates open.
REQ-035 trap_req_o is registered; never asserts in the cycle global_ie_i first rises.

Reset
REQ-036 All outputs, en_o, pend_o, sync flops reset to 0; FSM to IDLE; id/cause/offset to 0.
REQ-037 Reset mid-REQ/ACTIVE abandons the trap; edges during reset are lost.

Structure
REQ-038 utils_pkg holds irq_state_t enum (IDLE, REQ, ACTIVE) and MCAUSE_LOCAL_BASE = 16.
REQ-039 One sub-module irq_sync (parametrised SYNC_STAGES, width NUM_IRQ) instantiated once.
REQ-040 Priority encoder is a function inside irq_ctrl; no further hierarchy.

Verification
REQ-041 en=0x0003, global_ie=1, pulse irq_i[1] (edge) -> trap_req_o after 4 cycles, id 1, cause 0x8000_0011, offset 0x4.
REQ-042 irq_i[5] and irq_i[2] asserted together, both enabled -> id 2 first; after complete(2) -> id 5 requested.
REQ-043 Level line 3 drops while in REQ -> trap_req_o stays 1 with id 3 until trap_ack_i.
REQ-044 In ACTIVE with id 4: complete_id 7 -> remains ACTIVE, busy_o=1; complete_id 4 -> IDLE next cycle.
REQ-045 Edge on line 0 coincident with ack of line 0 -> pend_o[0] remains 1, new request after complete.
REQ-046 rst asserted while ACTIVE -> busy_o, trap_req_o, pend_o, en_o all 0 immediately (async).

Source files
------------

// File: rtl/utils_pkg.sv
`default_nettype none
// ============================================================================
// Module : utils_pkg
// Brief  : Shared types and constants for the local interrupt controller.
// Rev    : 1.0  initial release
// ============================================================================
package utils_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } irq_state_t;

  // mcause code of local interrupt 0; line n reports MCAUSE_LOCAL_BASE + n
  localparam int          MCAUSE_LOCAL_BASE = 16;
  localparam logic [31:0] MCAUSE_IRQ_BIT    = 32'h8000_0000;

  // mcause value for a local interrupt id (id already zero-extended)
  function automatic logic [31:0] local_mcause(input logic [31:0] id);
    return MCAUSE_IRQ_BIT | (32'(MCAUSE_LOCAL_BASE) + id);
  endfunction

endpackage : utils_pkg
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module : irq_sync
// Brief  : Multi-flop synchroniser bank for asynchronous interrupt lines.
// Rev    : 1.0  initial release
// ============================================================================
module irq_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      // First stage captures the raw asynchronous lines
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain[s] <= '0;
        else      chain[s] <= async_in;
      end
    end else begin : g_rest
      // Later stages resolve metastability of the previous stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain[s] <= '0;
        else      chain[s] <= chain[s-1];
      end
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule : irq_sync
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : irq_ctrl
// Brief  : Local interrupt controller. Synchronises raw lines, keeps a
//          pending vector (level or rising-edge latched per line), picks the
//          lowest enabled pending line and runs a non-nesting
//          IDLE -> REQ -> ACTIVE handshake with the CSR unit.
// Rev    : 1.0  initial release
// ============================================================================
module irq_ctrl
  import utils_pkg::*;
#(
  parameter int                 NUM_IRQ     = 16,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 VEC_STRIDE  = 4,
  localparam int                ID_W        = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               en_wr_i,
  input  logic [NUM_IRQ-1:0] en_data_i,
  input  logic               global_ie_i,
  input  logic               stall_i,
  input  logic               trap_ack_i,
  input  logic               complete_i,
  input  logic [ID_W-1:0]    complete_id_i,
  output logic [NUM_IRQ-1:0] en_o,
  output logic [NUM_IRQ-1:0] pend_o,
  output logic               trap_req_o,
  output logic [ID_W-1:0]    trap_id_o,
  output logic [31:0]        trap_cause_o,
  output logic [31:0]        trap_offset_o,
  output logic               busy_o
);

  // Lowest set index wins; returns {valid, index}
  function automatic logic [ID_W:0] find_first(input logic [NUM_IRQ-1:0] v);
    logic [ID_W:0] r;
    r = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = {1'b1, ID_W'(i)};
    end
    return r;
  endfunction

  logic [NUM_IRQ-1:0] sync_lvl;
  logic [NUM_IRQ-1:0] sync_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] pend_bits;
  logic [NUM_IRQ-1:0] en_bits;
  logic [ID_W:0]      cand;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_id;
  logic               take_irq;
  logic [31:0]        cand_cause;
  logic [31:0]        cand_offset;
  irq_state_t         state;
  logic               req_flag;
  logic [ID_W-1:0]    cur_id;
  logic [31:0]        cur_cause;
  logic [31:0]        cur_offset;

  irq_sync #(
    .WIDTH       (NUM_IRQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (irq_i),
    .sync_out (sync_lvl)
  );

  // Previous synchronised level, used to detect rising edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_prev <= '0;
    else      sync_prev <= sync_lvl;
  end

  // Next pending vector: level lines follow the line, edge lines latch
  // rises and are cleared by the ack of the served id (a new rise wins)
  always_comb begin
    rise    = sync_lvl & ~sync_prev;
    ack_clr = '0;
    if (state == REQ && trap_ack_i) ack_clr[cur_id] = 1'b1;
    pend_nxt = (EDGE_MASK & (rise | (pend_bits & ~ack_clr)))
             | (~EDGE_MASK & sync_lvl);
  end

  // Pending register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_bits <= '0;
    else      pend_bits <= pend_nxt;
  end

  // Enable register; disabling a line leaves its pending bit alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         en_bits <= '0;
    else if (en_wr_i) en_bits <= en_data_i;
  end

  // Candidate selection and the values latched when a request starts
  always_comb begin
    cand        = find_first(pend_bits & en_bits);
    cand_valid  = cand[ID_W];
    cand_id     = cand[ID_W-1:0];
    take_irq    = (state == IDLE) && global_ie_i && cand_valid && !stall_i;
    cand_cause  = local_mcause(32'(cand_id));
    cand_offset = 32'(cand_id) * 32'(VEC_STRIDE);
  end

  // Request/serve FSM; id, cause and offset freeze at IDLE->REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_flag   <= 1'b0;
      cur_id     <= '0;
      cur_cause  <= '0;
      cur_offset <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_irq) begin
            state      <= REQ;
            req_flag   <= 1'b1;
            cur_id     <= cand_id;
            cur_cause  <= cand_cause;
            cur_offset <= cand_offset;
          end
        end
        REQ: begin
          if (trap_ack_i) begin
            state    <= ACTIVE;
            req_flag <= 1'b0;
          end
        end
        ACTIVE: begin
          if (complete_i && complete_id_i == cur_id) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          req_flag <= 1'b0;
        end
      endcase
    end
  end

  assign en_o          = en_bits;
  assign pend_o        = pend_bits;
  assign trap_req_o    = req_flag;
  assign trap_id_o     = cur_id;
  assign trap_cause_o  = cur_cause;
  assign trap_offset_o = cur_offset;
  assign busy_o        = (state != IDLE);

endmodule : irq_ctrl
`default_nettype wire
